// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and sizes for the truth-table sweep controller
package tt_sweep_pkg;
  localparam int VEC_W = 4;
  localparam int N_VEC = 16;
  localparam int CNT_W = 5;
  localparam logic [N_VEC-1:0] DEFAULT_EXPECTED = 16'h7310;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} sweepState;
endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// tt_sweep_ctrl_if: host/function-block signals of the sweep controller; slave = controller side
interface tt_sweep_ctrl_if;
  import tt_sweep_pkg::*;
  logic start, s, a, b, c, d, busy, done, pass;
  logic [N_VEC-1:0] table_q;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [VEC_W-1:0] first_err_idx;
  modport master (output start, s, input a, b, c, d, busy, done, pass, table_q, mismatch_cnt, first_err_idx);
  modport slave (input start, s, output a, b, c, d, busy, done, pass, table_q, mismatch_cnt, first_err_idx);
endinterface

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter, tc while the count sits at zero
module tt_settle_timer #(parameter int W = 4) (
  input logic clk,
  input logic reset,
  input logic load,
  input logic en,
  input logic [W-1:0] loadVal,
  output logic tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= loadVal;
    else if (en && !tc) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: exhaustive 16-vector sweep of a 4-input function block with truth-table check
// Optional TT_STOP_ON_ERR_EN ends the sweep at the first mismatching vector.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter logic [N_VEC-1:0] EXPECTED = DEFAULT_EXPECTED
) (
  input logic clk,
  input logic reset,
  tt_sweep_ctrl_if.slave io
);
  sweepState state;
  logic [VEC_W-1:0] idx, firstErrIdx;
  logic [N_VEC-1:0] tableQ;
  logic [CNT_W-1:0] mismatchCnt;
  logic busy, done, pass, miss, last, accept, reload, settled;
  assign miss = io.s != EXPECTED[idx];
  assign accept = state == IDLE && io.start;
`ifdef TT_STOP_ON_ERR_EN
  assign last = idx == VEC_W'(N_VEC - 1) || miss;
`else
  assign last = idx == VEC_W'(N_VEC - 1);
`endif
  assign reload = accept || (state == SAMPLE && !last);
  // timer holds SETTLE_CYCLES-1 on entry so DRIVE lasts exactly SETTLE_CYCLES cycles
  tt_settle_timer #(.W($clog2(N_VEC))) timer (
    .clk(clk),
    .reset(reset),
    .load(reload),
    .en(state == DRIVE),
    .loadVal(VEC_W'(SETTLE_CYCLES - 1)),
    .tc(settled)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      tableQ <= '0;
      mismatchCnt <= '0;
      firstErrIdx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (io.start) begin
          state <= DRIVE;
          idx <= '0;
          tableQ <= '0;
          mismatchCnt <= '0;
          firstErrIdx <= '0;
          pass <= 1'b0;
          busy <= 1'b1;
        end
        DRIVE: if (settled) state <= SAMPLE;
        SAMPLE: begin
          tableQ[idx] <= io.s;
          if (miss) mismatchCnt <= mismatchCnt + 1'b1;
          if (miss && mismatchCnt == '0) firstErrIdx <= idx;
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            pass <= mismatchCnt == '0 && !miss;
          end else begin
            state <= DRIVE;
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          idx <= '0;
          busy <= 1'b0;
        end
      endcase
    end
  assign {io.a, io.b, io.c, io.d} = idx;
  assign io.busy = busy;
  assign io.done = done;
  assign io.pass = pass;
  assign io.table_q = tableQ;
  assign io.mismatch_cnt = mismatchCnt;
  assign io.first_err_idx = firstErrIdx;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: scoreboard bench for tt_sweep_ctrl with SETTLE_CYCLES=1 and 3
module tb_tt_sweep_ctrl;
  localparam logic [15:0] EXP = 16'h7310;
  typedef struct packed {
    logic [15:0] tbl;
    logic [4:0] cnt;
    logic [3:0] first;
    logic pass;
    int lat;
  } expT;
  logic clk = 1'b0, reset = 1'b1;
  int mode1 = 0, mode3 = 0, errors = 0, checks = 0;
  expT q[$];
  always #5 clk = ~clk;
  tt_sweep_ctrl_if if1 ();
  tt_sweep_ctrl_if if3 ();
  tt_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .io(if1.slave));
  tt_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .io(if3.slave));

  // function block: 0 = correct, 1 = stuck-at-1, 2 = inverted at index 9
  function automatic logic sval(int mode, logic [3:0] i);
    logic [15:0] e;
    e = EXP;
    return mode == 1 ? 1'b1 : mode == 2 && i == 4'd9 ? ~e[i] : e[i];
  endfunction
  assign if1.s = sval(mode1, {if1.a, if1.b, if1.c, if1.d});
  assign if3.s = sval(mode3, {if3.a, if3.b, if3.c, if3.d});

  function automatic expT model(int mode, int settle);
    expT r;
    logic [15:0] e;
    logic v;
    int lastIdx;
    r = '0;
    e = EXP;
    lastIdx = 15;
    for (int i = 0; i < 16; i++) begin
      v = sval(mode, 4'(i));
      r.tbl[i] = v;
      if (v != e[i]) begin
        if (r.cnt == 0) r.first = 4'(i);
        r.cnt = r.cnt + 5'd1;
`ifdef TT_STOP_ON_ERR_EN
        lastIdx = i;
        break;
`endif
      end
    end
    r.pass = r.cnt == 0;
    r.lat = (lastIdx + 1) * (settle + 1) + 1;
    return r;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    if1.start = 1'b0;
    if3.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if1.a, if1.b, if1.c, if1.d, if1.busy, if1.done, if1.pass} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {if1.a, if1.b, if1.c, if1.d, if1.busy, if1.done, if1.pass});
    end
    checks++;
    if ({if1.table_q, if1.mismatch_cnt, if1.first_err_idx} !== 25'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {if1.table_q, if1.mismatch_cnt, if1.first_err_idx});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep(input int mode, input string name);
    expT e;
    int lat;
    mode1 = mode;
    q.push_back(model(mode, 1));
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    lat = 1;
    while (!if1.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    e = q.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, e.lat); end
    checks++;
    if (if1.table_q !== e.tbl) begin errors++; $display("FAIL %s table_q got %h want %h", name, if1.table_q, e.tbl); end
    checks++;
    if (if1.mismatch_cnt !== e.cnt) begin errors++; $display("FAIL %s mismatch_cnt got %0d want %0d", name, if1.mismatch_cnt, e.cnt); end
    checks++;
    if (if1.first_err_idx !== e.first) begin errors++; $display("FAIL %s first_err_idx got %0d want %0d", name, if1.first_err_idx, e.first); end
    checks++;
    if (if1.pass !== e.pass || if1.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s pass/busy at done got %b%b want %b1", name, if1.pass, if1.busy, e.pass);
    end
    @(negedge clk);
    checks++;
    if ({if1.busy, if1.done, if1.a, if1.b, if1.c, if1.d} !== 6'd0 || if1.pass !== e.pass) begin
      errors++;
      $display("FAIL %s idle_after got busy=%b done=%b abcd=%b pass=%b", name, if1.busy, if1.done, {if1.a, if1.b, if1.c, if1.d}, if1.pass);
    end
  endtask

  task automatic test_ignore_start;
    int lat, dones;
    bit busyDrop;
    mode1 = 0;
    busyDrop = 0;
    dones = 0;
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    lat = 1;
    while (!if1.done && lat < 200) begin
      if (!if1.busy) busyDrop = 1;
      @(negedge clk);
      lat++;
      if1.start = lat == 10;
    end
    if1.start = 1'b0;
    checks++;
    if (lat !== 33 || busyDrop) begin errors++; $display("FAIL ignore_start latency got %0d busyDrop=%0d want 33 0", lat, busyDrop); end
    repeat (40) begin
      @(negedge clk);
      if (if1.done || if1.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL ignore_start queued activity got %0d want 0", dones); end
  endtask

  task automatic test_held_start;
    int lat;
    mode1 = 0;
    if1.start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!if1.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    checks++;
    if (if1.busy !== 1'b0) begin errors++; $display("FAIL held_start idle busy got %b want 0", if1.busy); end
    @(negedge clk);
    if1.start = 1'b0;
    checks++;
    if (if1.busy !== 1'b1 || lat !== 33) begin errors++; $display("FAIL held_start restart busy=%b lat=%0d want 1 33", if1.busy, lat); end
    lat = 0;
    while (!if1.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dones;
    mode1 = 1;
    dones = 0;
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({if1.a, if1.b, if1.c, if1.d, if1.busy, if1.done, if1.pass, if1.table_q, if1.mismatch_cnt, if1.first_err_idx} !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid outputs got %h want 0", {if1.a, if1.b, if1.c, if1.d, if1.busy, if1.done, if1.pass, if1.table_q, if1.mismatch_cnt, if1.first_err_idx});
    end
    repeat (40) begin
      @(negedge clk);
      if (if1.done || if1.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_mid activity after abort got %0d want 0", dones); end
    test_sweep(0, "after_reset");
  endtask

  task automatic test_settle3;
    expT e;
    int lat;
    mode3 = 2;
    q.push_back(model(2, 3));
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    lat = 1;
    while (!if3.done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    e = q.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL settle3 latency got %0d want %0d", lat, e.lat); end
    checks++;
    if (if3.table_q !== e.tbl) begin errors++; $display("FAIL settle3 table_q got %h want %h", if3.table_q, e.tbl); end
    checks++;
    if (if3.mismatch_cnt !== e.cnt || if3.first_err_idx !== e.first || if3.pass !== e.pass) begin
      errors++;
      $display("FAIL settle3 cnt/first/pass got %0d %0d %b want %0d %0d %b", if3.mismatch_cnt, if3.first_err_idx, if3.pass, e.cnt, e.first, e.pass);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sweep(0, "correct");
    test_sweep(1, "stuck_one");
    test_sweep(2, "flip9");
    test_ignore_start();
    test_held_start();
    test_reset_mid();
    test_settle3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
